// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and register offsets for the memory-mapped UART transmitter.
package mmio_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [1:0] UART_TXDATA  = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_BAUDDIV = 2'd2;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Processor-side memory bus controls: address and active-low strobes.
interface mmio_uart_tx_if;

    logic [15:0] address;
    logic        re_L;
    logic        we_L;

    modport master (output address, output re_L, output we_L);
    modport slave  (input address, input re_L, input we_L);

endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO; a push while full is dropped even if a pop coincides.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_L,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = cnt_q == FULL_CNT;
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Bus-responder UART transmitter: register window, byte FIFO and 8N1 shifter.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] RESET_DIV  = 16'd434
) (
    input  logic          clock,
    input  logic          reset_L,
    mmio_uart_tx_if.slave bus,
    inout  wire  [15:0]   data,
    output logic          tx,
    output logic          txBusy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    uart_state_t state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  idx_q, idx_d;
    logic        tx_q, tx_d;
    logic        ovr_q, ovr_d;

    logic [15:0] off, rdata;
    logic [1:0]  sel;
    logic        in_win, wr, push, pop, full, empty, busy;
    logic [7:0]  fifo_dout;
    logic [CW-1:0] count;
    logic [3:0]  cnt4;

    assign off    = bus.address - BASE_ADDR;
    assign in_win = off < 16'd3;
    assign sel    = off[1:0];
    assign wr     = !bus.we_L && in_win;
    assign push   = wr && (sel == UART_TXDATA);
    assign cnt4   = 4'(count);
    assign busy   = state_q != IDLE;
    assign tx     = tx_q;
    assign txBusy = busy | ~empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_L (reset_L),
        .push    (push),
        .pop     (pop),
        .din     (data[7:0]),
        .dout    (fifo_dout),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        case (sel)
            UART_TXDATA: rdata = {12'b0, cnt4};
            UART_STATUS: rdata = {8'b0, cnt4, ovr_q, busy, full, empty};
            default:     rdata = div_q;
        endcase
    end

    assign data = (!bus.re_L && in_win) ? rdata : 16'bz;

    always_comb begin
        ovr_d = ovr_q;
        div_d = div_q;
        if (push && full) begin
            ovr_d = 1'b1;
        end
        if (wr && (sel == UART_STATUS)) begin
            ovr_d = 1'b0;
        end
        if (wr && (sel == UART_BAUDDIV)) begin
            div_d = (data == 16'd0) ? 16'd1 : data;
        end
    end

    // Bit counter counts down remaining cycles of the current bit.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    cnt_d   = div_q - 16'd1;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = div_q - 16'd1;
                    idx_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = div_q - 16'd1;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == 16'd0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        cnt_d   = div_q - 16'd1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Line level follows the next state so tx comes straight off a flop.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state_q <= IDLE;
            shift_q <= 8'd0;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            tx_q    <= 1'b1;
            ovr_q   <= 1'b0;
            div_q   <= RESET_DIV;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            ovr_q   <= ovr_d;
            div_q   <= div_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, framing, FIFO and reset.
module tb_mmio_uart_tx;

    logic        clock   = 1'b0;
    logic        reset_L = 1'b0;
    logic        tb_oe   = 1'b0;
    logic [15:0] tb_wd   = 16'h0000;
    logic        tx, txBusy;
    logic [15:0] rv;
    int          n_checks = 0;
    int          n_fail   = 0;
    wire  [15:0] data;

    mmio_uart_tx_if bus ();

    // Weak pull lets the bench see an undriven bus as all ones.
    for (genvar g = 0; g < 16; g++) begin : g_pull
        pullup (data[g]);
    end

    assign data = tb_oe ? tb_wd : 16'bz;

    mmio_uart_tx u_dut (
        .clock   (clock),
        .reset_L (reset_L),
        .bus     (bus),
        .data    (data),
        .tx      (tx),
        .txBusy  (txBusy)
    );

    always #5 clock = ~clock;

    task automatic bus_write(input logic [15:0] a, input logic [15:0] v);
        @(negedge clock);
        bus.address = a;
        tb_wd       = v;
        tb_oe       = 1'b1;
        bus.we_L    = 1'b0;
        @(posedge clock);
        #1;
        bus.we_L = 1'b1;
        tb_oe    = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] v);
        bus.address = a;
        bus.re_L    = 1'b0;
        #1;
        v        = data;
        bus.re_L = 1'b1;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_L = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset_L = 1'b1;
    endtask

    // Must be entered on the negedge holding the first start-bit cycle.
    task automatic expect_frames(input logic [7:0] b0, input logic [7:0] b1,
                                 input int nfr, input int div, input string nm);
        logic [19:0] bits;
        int errs;
        int fi;
        bits = {1'b1, b1, 1'b0, 1'b1, b0, 1'b0};
        errs = 0;
        fi   = -1;
        for (int i = 0; i < nfr * 10; i++) begin
            for (int c = 0; c < div; c++) begin
                if (tx !== bits[i]) begin
                    errs++;
                    if (fi < 0) fi = i * div + c;
                end
                @(negedge clock);
            end
        end
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL %s: %0d bad tx cycles (first at %0d), required 0",
                     nm, errs, fi);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (tx !== 1'b1) begin
            n_fail++; $display("FAIL reset_tx: got %b want 1", tx);
        end
        n_checks++;
        if (txBusy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", txBusy);
        end
        bus_read(16'hFF01, rv);
        n_checks++;
        if (rv !== 16'h0001) begin
            n_fail++; $display("FAIL reset_status: got %h want 0001", rv);
        end
        bus_read(16'hFF02, rv);
        n_checks++;
        if (rv !== 16'd434) begin
            n_fail++; $display("FAIL reset_div: got %h want 01b2", rv);
        end
        bus_read(16'hFF00, rv);
        n_checks++;
        if (rv !== 16'h0000) begin
            n_fail++; $display("FAIL reset_txdata: got %h want 0000", rv);
        end
    endtask

    task automatic test_single();
        bus_write(16'hFF02, 16'd4);
        bus_read(16'hFF02, rv);
        n_checks++;
        if (rv !== 16'd4) begin
            n_fail++; $display("FAIL div_rw: got %h want 0004", rv);
        end
        bus_write(16'hFF00, 16'h0055);
        bus_read(16'hFF01, rv);
        n_checks++;
        if (rv !== 16'h0010) begin
            n_fail++; $display("FAIL status_after_push: got %h want 0010", rv);
        end
        @(negedge clock);
        n_checks++;
        if (tx !== 1'b1) begin
            n_fail++; $display("FAIL latency_high: got %b want 1", tx);
        end
        @(negedge clock);
        expect_frames(8'h55, 8'h00, 1, 4, "single_frame");
        n_checks++;
        if (tx !== 1'b1 || txBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: got tx=%b busy=%b want 1 0", tx, txBusy);
        end
    endtask

    task automatic test_back_to_back();
        bus_write(16'hFF02, 16'd2);
        bus_write(16'hFF00, 16'h00FF);
        bus_write(16'hFF00, 16'h0000);
        @(negedge clock);
        expect_frames(8'hFF, 8'h00, 2, 2, "b2b_frames");
        n_checks++;
        if (tx !== 1'b1 || txBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got tx=%b busy=%b want 1 0", tx, txBusy);
        end
    endtask

    task automatic test_div_zero();
        bus_write(16'hFF02, 16'd0);
        bus_read(16'hFF02, rv);
        n_checks++;
        if (rv !== 16'h0001) begin
            n_fail++; $display("FAIL div_zero_read: got %h want 0001", rv);
        end
        bus_write(16'hFF00, 16'h00A5);
        @(negedge clock);
        @(negedge clock);
        expect_frames(8'hA5, 8'h00, 1, 1, "div1_frame");
        n_checks++;
        if (txBusy !== 1'b0) begin
            n_fail++; $display("FAIL div1_end: got busy=%b want 0", txBusy);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        bus_write(16'hFF02, 16'd1000);
        for (int i = 0; i < 10; i++) begin
            bus_write(16'hFF00, 16'(i + 1));
            if (i == 8) begin
                bus_read(16'hFF01, rv);
                n_checks++;
                if (rv !== 16'h0086) begin
                    n_fail++; $display("FAIL ovf_ninth: got %h want 0086", rv);
                end
            end
        end
        bus_read(16'hFF01, rv);
        n_checks++;
        if (rv !== 16'h008E) begin
            n_fail++; $display("FAIL ovf_status: got %h want 008e", rv);
        end
        bus_read(16'hFF00, rv);
        n_checks++;
        if (rv !== 16'h0008) begin
            n_fail++; $display("FAIL ovf_count: got %h want 0008", rv);
        end
        bus_write(16'hFF01, 16'hBEEF);
        bus_read(16'hFF01, rv);
        n_checks++;
        if (rv !== 16'h0086) begin
            n_fail++; $display("FAIL ovf_clear: got %h want 0086", rv);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        apply_reset();
        bus_write(16'hFF02, 16'd4);
        bus_write(16'hFF00, 16'h000F);
        bus_write(16'hFF00, 16'h0033);
        repeat (8) @(negedge clock);
        reset_L = 1'b0;
        @(posedge clock);
        #1;
        n_checks++;
        if (tx !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_tx: got %b want 1", tx);
        end
        bus_read(16'hFF01, rv);
        n_checks++;
        if (rv !== 16'h0001) begin
            n_fail++; $display("FAIL rst_mid_status: got %h want 0001", rv);
        end
        @(negedge clock);
        reset_L = 1'b1;
        bus_read(16'hFF02, rv);
        n_checks++;
        if (rv !== 16'd434) begin
            n_fail++; $display("FAIL rst_mid_div: got %h want 01b2", rv);
        end
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (tx !== 1'b1 || txBusy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_isolation();
        @(negedge clock);
        bus_read(16'hFEFF, rv);
        n_checks++;
        if (rv !== 16'hFFFF) begin
            n_fail++; $display("FAIL iso_feff: got %h want ffff (undriven)", rv);
        end
        bus_read(16'hFF03, rv);
        n_checks++;
        if (rv !== 16'hFFFF) begin
            n_fail++; $display("FAIL iso_ff03: got %h want ffff (undriven)", rv);
        end
        bus_write(16'hFF03, 16'h1234);
        bus_write(16'hFEFF, 16'h0055);
        @(negedge clock);
        bus_read(16'hFF02, rv);
        n_checks++;
        if (rv !== 16'd434) begin
            n_fail++; $display("FAIL iso_div: got %h want 01b2", rv);
        end
        bus_read(16'hFF01, rv);
        n_checks++;
        if (rv !== 16'h0001) begin
            n_fail++; $display("FAIL iso_status: got %h want 0001", rv);
        end
        n_checks++;
        if (txBusy !== 1'b0 || tx !== 1'b1) begin
            n_fail++;
            $display("FAIL iso_idle: got tx=%b busy=%b want 1 0", tx, txBusy);
        end
    endtask

    initial begin
        bus.address = 16'h0000;
        bus.re_L    = 1'b1;
        bus.we_L    = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_div_zero();
        test_overflow();
        test_reset_mid();
        test_isolation();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
